// File: rtl/mash_111_accumulator_if.sv
// Bus between a MASH 1-1-1 accumulator and its driver: fraction load,
// accumulate enable, the three carry streams and the pipeline-filled flag.
interface mash_111_accumulator_if #(
  parameter int P_WIDTH = 16
);
  logic               i_en;
  logic               i_frac_load;
  logic [P_WIDTH-1:0] i_frac;
  logic               o_quantize1;
  logic               o_quantize2;
  logic               o_quantize3;
  logic               o_valid;

  // Driver side: supplies the fraction and enable, observes the carries.
  modport master (
    output i_en, i_frac_load, i_frac,
    input  o_quantize1, o_quantize2, o_quantize3, o_valid
  );

  // Accumulator side.
  modport slave (
    input  i_en, i_frac_load, i_frac,
    output o_quantize1, o_quantize2, o_quantize3, o_valid
  );
endinterface

// File: rtl/mash_111_accumulator.sv
// Three-stage pipelined MASH 1-1-1 accumulator chain. Each stage integrates
// the registered residue of the previous stage, so stage k's carry lags
// stage k-1 by one enabled edge. Optional LFSR LSB dither on stage 1.
module mash_111_accumulator #(
  parameter int P_WIDTH  = 16,
  parameter int P_DITHER = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  mash_111_accumulator_if.slave bus
);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [P_WIDTH-1:0] frac_q, frac_d;
  logic [P_WIDTH-1:0] e_q [3];
  logic [P_WIDTH-1:0] e_d [3];
  logic [2:0]         c_q, c_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [1:0]         fill_q, fill_d;
  logic [P_WIDTH:0]   sum [3];
  logic               dither;
  logic               lfsr_fb;

  assign dither  = (P_DITHER != 0) && lfsr_q[0];
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // Stage 1 integrates the fraction (plus dither); the extra MSB is the carry.
  assign sum[0] = {1'b0, e_q[0]} + {1'b0, frac_q} + {{P_WIDTH{1'b0}}, dither};

  // Later stages integrate the previous stage's registered residue.
  generate
    for (genvar gi = 1; gi < 3; gi++) begin : g_stage
      assign sum[gi] = {1'b0, e_q[gi]} + {1'b0, e_q[gi-1]};
    end
  endgenerate

  // Next-state: fraction load is independent of enable; everything else holds when disabled.
  always_comb begin
    frac_d = bus.i_frac_load ? bus.i_frac : frac_q;
    e_d    = e_q;
    c_d    = c_q;
    lfsr_d = lfsr_q;
    fill_d = fill_q;
    if (bus.i_en) begin
      for (int i = 0; i < 3; i++) begin
        e_d[i] = sum[i][P_WIDTH-1:0];
        c_d[i] = sum[i][P_WIDTH];
      end
      lfsr_d = {lfsr_fb, lfsr_q[15:1]};
      fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    end
  end

  // Pipeline state register with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frac_q <= '0;
      for (int i = 0; i < 3; i++) begin
        e_q[i] <= '0;
      end
      c_q    <= '0;
      lfsr_q <= LFSR_SEED;
      fill_q <= '0;
    end else begin
      frac_q <= frac_d;
      e_q    <= e_d;
      c_q    <= c_d;
      lfsr_q <= lfsr_d;
      fill_q <= fill_d;
    end
  end

  assign bus.o_quantize1 = c_q[0];
  assign bus.o_quantize2 = c_q[1];
  assign bus.o_quantize3 = c_q[2];
  assign bus.o_valid     = (fill_q == 2'd3);

endmodule

// File: tb/tb_mash_111_accumulator.sv
// Self-checking bench: table of half-rate vectors, directed multi-cycle
// sequences, and a randomized run against an arithmetic reference model.
// Two instances run in lockstep: dut0 without dither, dut1 with dither.
module tb_mash_111_accumulator;

  localparam int W = 16;
  localparam int M = 1 << W;

  logic clk;
  logic rst_n;

  mash_111_accumulator_if #(.P_WIDTH(W)) bus0 ();
  mash_111_accumulator_if #(.P_WIDTH(W)) bus1 ();

  mash_111_accumulator #(.P_WIDTH(W), .P_DITHER(0)) dut0 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus0)
  );

  mash_111_accumulator #(.P_WIDTH(W), .P_DITHER(1)) dut1 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = no dither, 1 = dither.
  int m_frac [2];
  int m_e1 [2];
  int m_e2 [2];
  int m_e3 [2];
  int m_c1 [2];
  int m_c2 [2];
  int m_c3 [2];
  int m_lfsr [2];
  int m_fill [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_frac[k] = 0; m_e1[k] = 0; m_e2[k] = 0; m_e3[k] = 0;
      m_c1[k] = 0; m_c2[k] = 0; m_c3[k] = 0;
      m_lfsr[k] = 'hACE1; m_fill[k] = 0;
    end
  endtask

  task automatic model_step(input bit en, input bit load, input int frac);
    int d, s1, s2, s3, fb;
    for (int k = 0; k < 2; k++) begin
      if (en) begin
        d  = (k == 1) ? (m_lfsr[k] % 2) : 0;
        s1 = m_e1[k] + m_frac[k] + d;
        s2 = m_e2[k] + m_e1[k];
        s3 = m_e3[k] + m_e2[k];
        m_c1[k] = (s1 >= M) ? 1 : 0;
        m_c2[k] = (s2 >= M) ? 1 : 0;
        m_c3[k] = (s3 >= M) ? 1 : 0;
        m_e1[k] = s1 % M;
        m_e2[k] = s2 % M;
        m_e3[k] = s3 % M;
        fb = ((m_lfsr[k] >> 0) ^ (m_lfsr[k] >> 2) ^ (m_lfsr[k] >> 3) ^ (m_lfsr[k] >> 5)) & 1;
        m_lfsr[k] = (m_lfsr[k] / 2) + fb * 32768;
        if (m_fill[k] < 3) m_fill[k] = m_fill[k] + 1;
      end
      if (load) m_frac[k] = frac;
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock edge: inputs driven after the falling edge, outputs sampled 1ns after the rising edge.
  task automatic step(input bit en, input bit load, input logic [15:0] frac);
    @(negedge clk);
    bus0.i_en = en; bus0.i_frac_load = load; bus0.i_frac = frac;
    bus1.i_en = en; bus1.i_frac_load = load; bus1.i_frac = frac;
    @(posedge clk);
    #1;
    model_step(en, load, int'(frac));
  endtask

  task automatic check_all_zero(input string name);
    check_bit({name, "_q1"}, bus0.o_quantize1, 1'b0);
    check_bit({name, "_q2"}, bus0.o_quantize2, 1'b0);
    check_bit({name, "_q3"}, bus0.o_quantize3, 1'b0);
    check_bit({name, "_valid"}, bus0.o_valid, 1'b0);
    check_bit({name, "_d_q1"}, bus1.o_quantize1, 1'b0);
    check_bit({name, "_d_valid"}, bus1.o_valid, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus0.i_en = 1'b0; bus0.i_frac_load = 1'b0; bus0.i_frac = '0;
    bus1.i_en = 1'b0; bus1.i_frac_load = 1'b0; bus1.i_frac = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic compare_model(input string name);
    check_bit({name, "_q1"}, bus0.o_quantize1, m_c1[0] != 0);
    check_bit({name, "_q2"}, bus0.o_quantize2, m_c2[0] != 0);
    check_bit({name, "_q3"}, bus0.o_quantize3, m_c3[0] != 0);
    check_bit({name, "_valid"}, bus0.o_valid, m_fill[0] == 3);
    check_bit({name, "_d_q1"}, bus1.o_quantize1, m_c1[1] != 0);
    check_bit({name, "_d_q2"}, bus1.o_quantize2, m_c2[1] != 0);
    check_bit({name, "_d_q3"}, bus1.o_quantize3, m_c3[1] != 0);
    check_bit({name, "_d_valid"}, bus1.o_valid, m_fill[1] == 3);
  endtask

  typedef struct {
    bit          en;
    bit          load;
    logic [15:0] frac;
    logic [3:0]  exp;   // {q1, q2, q3, valid}
  } vec_t;

  vec_t vecs [12];

  initial begin
    int ones;
    int en_cnt;
    logic [3:0] got;
    logic exp_q1;
    bit en;

    rst_n = 1'b0;
    bus0.i_en = 1'b0; bus0.i_frac_load = 1'b0; bus0.i_frac = '0;
    bus1.i_en = 1'b0; bus1.i_frac_load = 1'b0; bus1.i_frac = '0;
    model_reset();

    // Half-rate fraction, with a disabled cycle and a load of zero mid-stream.
    vecs[0]  = '{1'b0, 1'b1, 16'h8000, 4'b0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h0000, 4'b0000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0000, 4'b1000};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 4'b0001};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 4'b1111};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 4'b1111};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 4'b0001};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 4'b1001};
    vecs[8]  = '{1'b1, 1'b1, 16'h0000, 4'b0001};
    vecs[9]  = '{1'b1, 1'b0, 16'h0000, 4'b0111};
    vecs[10] = '{1'b1, 1'b0, 16'h0000, 4'b0001};
    vecs[11] = '{1'b1, 1'b0, 16'h0000, 4'b0101};

    #12;
    check_all_zero("reset_state");
    do_reset();
    check_all_zero("reset_release");

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].en, vecs[i].load, vecs[i].frac);
      got = {bus0.o_quantize1, bus0.o_quantize2, bus0.o_quantize3, bus0.o_valid};
      checks++;
      if (got !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d: got %b expected %b", i, got, vecs[i].exp);
      end
    end
    $display("table: %0d vectors applied", 12);

    // Zero input for 1000 enabled edges.
    do_reset();
    for (int k = 1; k <= 1000; k++) begin
      step(1'b1, 1'b0, 16'h0000);
      check_bit("zero_q", bus0.o_quantize1 | bus0.o_quantize2 | bus0.o_quantize3, 1'b0);
      check_bit("zero_valid", bus0.o_valid, k >= 3);
    end
    $display("zero: 1000 edges");

    // Half: alternating carry, 512 ones in 1024 edges.
    do_reset();
    step(1'b0, 1'b1, 16'h8000);
    ones = 0;
    for (int k = 1; k <= 1024; k++) begin
      step(1'b1, 1'b0, 16'h0000);
      check_bit("half_q1", bus0.o_quantize1, (k % 2) == 0);
      if (bus0.o_quantize1) ones++;
    end
    check_int("half_ones", ones, 512);
    $display("half: %0d ones", ones);

    // Quarter with random enable gaps; outputs frozen while disabled.
    do_reset();
    step(1'b0, 1'b1, 16'h4000);
    ones = 0; en_cnt = 0; exp_q1 = 1'b0;
    while (en_cnt < 1024) begin
      en = ($urandom_range(0, 2) != 0);
      step(en, 1'b0, 16'h0000);
      if (en) begin
        en_cnt++;
        exp_q1 = (en_cnt % 4) == 0;
        if (bus0.o_quantize1) ones++;
      end
      check_bit(en ? "quarter_q1" : "quarter_frozen_q1", bus0.o_quantize1, exp_q1);
    end
    check_int("quarter_ones", ones, 256);
    $display("quarter: %0d ones", ones);

    // Dither: full-scale fraction carries on the first edge only with dither.
    do_reset();
    step(1'b0, 1'b1, 16'hFFFF);
    step(1'b1, 1'b0, 16'h0000);
    check_bit("dither_on_q1", bus1.o_quantize1, 1'b1);
    check_bit("dither_off_q1", bus0.o_quantize1, 1'b0);
    check_int("dither_lfsr", int'(dut1.lfsr_q), 'h5670);
    $display("dither: lfsr=%h", dut1.lfsr_q);

    // Asynchronous reset mid-run during the half case, then an identical rerun.
    for (int run = 0; run < 2; run++) begin
      do_reset();
      step(1'b0, 1'b1, 16'h8000);
      for (int k = 1; k <= 6; k++) begin
        step(1'b1, 1'b0, 16'h0000);
        check_bit("rerun_q1", bus0.o_quantize1, (k % 2) == 0);
        check_bit("rerun_valid", bus0.o_valid, k >= 3);
      end
      if (run == 0) begin
        step(1'b1, 1'b0, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    $display("reset mid-run: done");

    // Randomized run against the reference model, both dither settings.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 16'($urandom));
      compare_model("rand");
    end
    $display("random: 3000 edges");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
